// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes, signs applied in FIX.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write hi/lo directly
// MUL   | shift-add iterations, one multiplier bit per cycle
// DIV   | restoring division iterations, one quotient bit per cycle
// FIX   | apply result signs, write hi/lo, pulse done
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic             unsigned_num,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIX  = 2'b11
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] acc;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               last_iter;
    logic               accept;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        sign_a    = ~unsigned_num & data_a[WIDTH-1];
        sign_b    = ~unsigned_num & data_b[WIDTH-1];
        mag_a     = sign_a ? (~data_a + 1'b1) : data_a;
        mag_b     = sign_b ? (~data_b + 1'b1) : data_b;
        last_iter = (cnt == CW'(WIDTH - 1));
        accept    = start & ~flush;

        // Multiplier sits in the low half and shifts out as the product shifts in.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_a} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};

        // Dividend sits in the low half; quotient bits fill in from the right.
        rem_sh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (rem_sh >= {1'b0, op_b});
        rem_sub   = rem_sh[WIDTH-1:0] - op_b;
        div_next  = div_ge ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                           : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

        prod_fix  = neg_res ? (~acc + 1'b1) : acc;
        quot_fix  = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix   = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept && md_op == OP_MUL) state_next = S_MUL;
                if (accept && md_op == OP_DIV) state_next = S_DIV;
            end
            S_MUL, S_DIV: begin
                if (flush)          state_next = S_IDLE;
                else if (last_iter) state_next = S_FIX;
            end
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            acc     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (state_next != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (md_op)
                            OP_MTHI: hi <= data_a;
                            OP_MTLO: lo <= data_a;
                            default: begin
                                op_a    <= mag_a;
                                op_b    <= mag_b;
                                is_div  <= (md_op == OP_DIV);
                                neg_res <= sign_a ^ sign_b;
                                neg_rem <= sign_a;
                                cnt     <= '0;
                                acc     <= (md_op == OP_DIV) ? {{WIDTH{1'b0}}, mag_a}
                                                             : {{WIDTH{1'b0}}, mag_b};
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    if (!flush) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            {hi, lo} <= prod_fix;
                        end else if (op_b != '0) begin
                            lo <= quot_fix;
                            hi <= rem_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed cases plus random operations checked
// against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    logic        clk, rst, start, unsigned_num, flush;
    logic [1:0]  md_op;
    logic [31:0] data_a, data_b;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic [31:0] hi_m, lo_m;
    int          checks = 0;
    int          errors = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .md_op(md_op),
        .unsigned_num(unsigned_num), .flush(flush),
        .data_a(data_a), .data_b(data_b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_md(input logic [1:0] op, input logic uns,
                            input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sq, sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == OP_MUL) begin
            if (uns) p = {32'b0, a} * {32'b0, b};
            else     p = 64'(sa * sb);
            hi_m = p[63:32];
            lo_m = p[31:0];
        end else if (b != 32'd0) begin
            if (uns) begin
                lo_m = a / b;
                hi_m = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                lo_m = 32'h8000_0000;
                hi_m = 32'h0;
            end else begin
                sq = sa / sb;
                sr = sa % sb;
                lo_m = sq[31:0];
                hi_m = sr[31:0];
            end
        end
    endtask

    // inj_kind: 0 none, 1 stray start after sample inj_cyc, 2 flush after sample inj_cyc
    task automatic run_op(input logic [1:0] op, input logic uns,
                          input logic [31:0] a, input logic [31:0] b,
                          input int inj_cyc, input int inj_kind);
        int   lat;
        logic busy_ok;
        logic seen_done;
        @(negedge clk);
        start = 1'b1; md_op = op; unsigned_num = uns; data_a = a; data_b = b;
        @(posedge clk); #1;
        start = 1'b0; md_op = 2'($urandom); unsigned_num = 1'($urandom);
        data_a = $urandom; data_b = $urandom;
        if (op[1]) begin
            if (op == OP_MTHI) hi_m = a; else lo_m = a;
            chk("mt_hi", 64'(hi), 64'(hi_m));
            chk("mt_lo", 64'(lo), 64'(lo_m));
            chk("mt_busy", 64'(busy), 64'd0);
            return;
        end
        busy_ok = busy & ~done;
        lat = 0;
        while (lat < 40) begin
            if (lat == inj_cyc && inj_kind == 1) begin
                start = 1'b1; md_op = 2'($urandom); data_a = $urandom; data_b = $urandom;
            end
            if (lat == inj_cyc && inj_kind == 2) flush = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; flush = 1'b0;
            lat++;
            if (inj_kind == 2 && lat == inj_cyc + 1) begin
                chk("flush_busy", 64'(busy), 64'd0);
                chk("flush_done", 64'(done), 64'd0);
                seen_done = 1'b0;
                repeat (40) begin
                    @(posedge clk); #1;
                    seen_done |= done;
                end
                chk("flush_no_done", 64'(seen_done), 64'd0);
                chk("flush_hi", 64'(hi), 64'(hi_m));
                chk("flush_lo", 64'(lo), 64'(lo_m));
                return;
            end
            if (done) break;
            busy_ok &= busy;
        end
        chk("latency", 64'(lat), 64'd33);
        chk("busy_run", 64'(busy_ok), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
        model_md(op, uns, a, b);
        chk("res_hi", 64'(hi), 64'(hi_m));
        chk("res_lo", 64'(lo), 64'(lo_m));
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; md_op = 2'b00;
        unsigned_num = 1'b0; data_a = '0; data_b = '0;
        hi_m = '0; lo_m = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(negedge clk); rst = 1'b0;

        run_op(OP_MUL, 1'b0, 32'hFFFF_FFFE, 32'd3, 0, 0);
        chk("smul_hi_const", 64'(hi), 64'hFFFF_FFFF);
        chk("smul_lo_const", 64'(lo), 64'hFFFF_FFFA);
        run_op(OP_MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 0, 0);
        chk("sdiv_lo_const", 64'(lo), 64'hFFFF_FFFD);
        run_op(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        chk("ovf_lo_const", 64'(lo), 64'h8000_0000);

        run_op(OP_MTHI, 1'b0, 32'h1234_5678, 32'd0, 0, 0);
        run_op(OP_MTLO, 1'b0, 32'h9ABC_DEF0, 32'd0, 0, 0);
        run_op(OP_DIV, 1'b0, 32'h0000_1234, 32'd0, 0, 0);
        chk("dz_hi_const", 64'(hi), 64'h1234_5678);

        run_op(OP_MUL, 1'b0, 32'h0001_2345, 32'hFFFF_0F0F, 5, 1);
        run_op(OP_MUL, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 10, 2);

        // flush beats a simultaneous start in IDLE
        @(negedge clk);
        start = 1'b1; flush = 1'b1; md_op = OP_MTHI; data_a = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("idle_flush_hi", 64'(hi), 64'(hi_m));
        @(negedge clk);
        start = 1'b1; flush = 1'b1; md_op = OP_MUL; data_a = 32'd5; data_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("idle_flush_busy", 64'(busy), 64'd0);

        // asynchronous reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; md_op = OP_DIV; unsigned_num = 1'b0;
        data_a = 32'h7654_3210; data_b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        hi_m = '0; lo_m = '0;
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        @(negedge clk); rst = 1'b0;
        run_op(OP_MUL, 1'b0, 32'd7, 32'd6, 0, 0);
        chk("post_rst_lo", 64'(lo), 64'd42);

        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 5) > 3 ? $urandom_range(2, 3) : $urandom_range(0, 1));
            run_op(op, 1'($urandom), pick_val(), pick_val(), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
